// File: rtl/vram_term_writer.sv
// Terminal character engine: consumes a byte stream, tracks an 80x30 cursor and emits
// single-cycle VRAM cell writes, including full-screen and single-row clears.
module vram_term_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ch_data,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic [7:0]  attr,
    output logic [31:0] a,
    output logic [31:0] d,
    output logic        we,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);

    localparam logic [6:0]  LastCol  = 7'(COLS - 1);
    localparam logic [4:0]  LastRow  = 5'(ROWS - 1);
    localparam logic [11:0] LastCell = 12'(COLS * ROWS - 1);
    localparam logic [11:0] RowLast  = 12'(COLS - 1);
    localparam logic [11:0] ColsW    = 12'(COLS);

    typedef enum logic [2:0] {
        StBoot,
        StInitClr,
        StIdle,
        StWrite,
        StClrRow,
        StClrAll
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  attr_q, attr_d;
    logic [7:0]  ch_q, ch_d;
    logic        bs_q, bs_d;
    logic [31:0] a_q, d_q;

    logic [11:0] row_base;
    logic [11:0] cell_idx;
    logic [7:0]  cell_code;
    logic [7:0]  cell_attr;
    logic [31:0] a_cur;
    logic [31:0] d_cur;
    logic        wrap_row;
    logic [4:0]  adv_row;
    logic        accept;

    assign row_base = 12'(row_q) * ColsW;
    assign wrap_row = (row_q == LastRow);
    assign adv_row  = wrap_row ? 5'd0 : row_q + 5'd1;
    assign accept   = ch_valid && (state_q == StIdle);

    // Cell being written this cycle, selected by the active state.
    always_comb begin
        cell_idx  = cnt_q;
        cell_code = 8'h20;
        cell_attr = attr_q;
        unique case (state_q)
            StWrite: begin
                cell_idx  = row_base + {5'd0, col_q};
                cell_code = ch_q;
            end
            StClrRow:  cell_idx = row_base + cnt_q;
            StInitClr: cell_attr = 8'h0F;
            default: ;
        endcase
    end

    assign a_cur = BASE_ADDR + {18'd0, cell_idx, 2'b00};
    assign d_cur = {cell_code, cell_attr, 16'h0000};

    assign we       = (state_q == StWrite) || (state_q == StInitClr) ||
                      (state_q == StClrRow) || (state_q == StClrAll);
    assign busy     = (state_q == StInitClr) || (state_q == StClrRow) ||
                      (state_q == StClrAll);
    assign ch_ready = (state_q == StIdle);
    assign a        = we ? a_cur : a_q;
    assign d        = we ? d_cur : d_q;
    assign cur_col  = col_q;
    assign cur_row  = row_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        attr_d  = attr_q;
        ch_d    = ch_q;
        bs_d    = bs_q;
        unique case (state_q)
            StBoot: begin
                cnt_d   = '0;
                state_d = StInitClr;
            end
            StInitClr, StClrAll: begin
                if (cnt_q == LastCell) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            StClrRow: begin
                if (cnt_q == RowLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            StIdle: begin
                if (accept) begin
                    attr_d = attr;
                    if (ch_data >= 8'h20 && ch_data != 8'h7F) begin
                        ch_d    = ch_data;
                        bs_d    = 1'b0;
                        state_d = StWrite;
                    end else if (ch_data == 8'h0D) begin
                        col_d = '0;
                    end else if (ch_data == 8'h0A) begin
                        col_d   = '0;
                        row_d   = adv_row;
                        cnt_d   = '0;
                        state_d = wrap_row ? StClrRow : StIdle;
                    end else if (ch_data == 8'h08) begin
                        if (col_q != 7'd0) begin
                            col_d   = col_q - 7'd1;
                            ch_d    = 8'h20;
                            bs_d    = 1'b1;
                            state_d = StWrite;
                        end
                    end else if (ch_data == 8'h0C) begin
                        col_d   = '0;
                        row_d   = '0;
                        cnt_d   = '0;
                        state_d = StClrAll;
                    end
                end
            end
            StWrite: begin
                state_d = StIdle;
                if (!bs_q) begin
                    if (col_q == LastCol) begin
                        col_d   = '0;
                        row_d   = adv_row;
                        cnt_d   = '0;
                        state_d = wrap_row ? StClrRow : StIdle;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StBoot;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            attr_q  <= 8'h0F;
            ch_q    <= 8'h20;
            bs_q    <= 1'b0;
            a_q     <= BASE_ADDR;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            attr_q  <= attr_d;
            ch_q    <= ch_d;
            bs_q    <= bs_d;
            if (we) begin
                a_q <= a_cur;
                d_q <= d_cur;
            end
        end
    end

endmodule

// File: tb/tb_vram_term_writer.sv
// Scoreboarded bench: stimulus queues expected VRAM writes, a negedge monitor pops and checks.
module tb_vram_term_writer;

    localparam logic [31:0] Base = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ch_data = 8'h00;
    logic        ch_valid = 1'b0;
    logic        ch_ready;
    logic [7:0]  attr = 8'h00;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    vram_term_writer #(
        .BASE_ADDR(Base),
        .COLS(80),
        .ROWS(30)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch_data(ch_data),
        .ch_valid(ch_valid),
        .ch_ready(ch_ready),
        .attr(attr),
        .a(a),
        .d(d),
        .we(we),
        .cur_col(cur_col),
        .cur_row(cur_row),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && we) begin
            logic [63:0] e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got a=%h d=%h expected no write", a, d);
            end else begin
                e = sb.pop_front();
                if ({a, d} !== e) begin
                    errors++;
                    $display("FAIL vram_write: got a=%h d=%h expected a=%h d=%h",
                             a, d, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic push_cell(input int idx, input logic [7:0] c, input logic [7:0] at);
        sb.push_back({Base + 32'(4 * idx), c, at, 16'h0000});
    endtask

    task automatic push_clr(input int start, input int n, input logic [7:0] at);
        for (int i = 0; i < n; i++) push_cell(start + i, 8'h20, at);
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (!ch_ready && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!ch_ready) begin
            errors++;
            $display("FAIL ready_timeout: got ch_ready=0 expected 1 within %0d cycles", max);
        end
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic [7:0] c, input logic [7:0] at);
        wait_ready(3000);
        ch_data  = c;
        attr     = at;
        ch_valid = 1'b1;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check({name, "_col"}, 32'(cur_col), 32'(col));
        check({name, "_row"}, 32'(cur_row), 32'(row));
    endtask

    initial begin
        // Reset values
        #22;
        check("rst_we", 32'(we), 32'd0);
        check("rst_ready", 32'(ch_ready), 32'd0);
        check("rst_a", a, Base);
        check("rst_d", d, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check_cursor("rst_cursor", 0, 0);

        // Power-up clear
        push_clr(0, 2400, 8'h0F);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("init_busy", 32'(busy), 32'd1);
        check("init_ready", 32'(ch_ready), 32'd0);
        wait_ready(2500);
        check("init_sb_empty", 32'(sb.size()), 32'd0);
        check_cursor("init_cursor", 0, 0);

        // 'A' with attr 0x1E
        push_cell(0, 8'h41, 8'h1E);
        send(8'h41, 8'h1E);
        check("a_we", 32'(we), 32'd1);
        check("a_d", d, 32'h411E0000);
        check("a_ready_n1", 32'(ch_ready), 32'd0);
        @(posedge clk);
        #1;
        check("a_ready_n2", 32'(ch_ready), 32'd1);
        check_cursor("a_cursor", 1, 0);

        // CR is immediate and allows back-to-back accepts
        send(8'h0D, 8'h1E);
        check("cr_ready", 32'(ch_ready), 32'd1);
        check_cursor("cr_cursor", 0, 0);

        // Full row of printables wraps to the next row
        for (int i = 0; i < 80; i++) begin
            push_cell(i, 8'h61 + 8'(i % 26), 8'h1E);
            send(8'h61 + 8'(i % 26), 8'h1E);
        end
        wait_ready(10);
        check_cursor("row_wrap_cursor", 0, 1);

        // BS at col 0 is a no-op; BS after 'X' blanks it
        send(8'h0D, 8'h2A);
        send(8'h08, 8'h2A);
        check("bs0_ready", 32'(ch_ready), 32'd1);
        check_cursor("bs0_cursor", 0, 1);
        push_cell(80, 8'h58, 8'h2A);
        send(8'h58, 8'h2A);
        push_cell(80, 8'h20, 8'h2A);
        send(8'h08, 8'h2A);
        wait_ready(10);
        check_cursor("bs_cursor", 0, 1);

        // Ignored codes
        send(8'h7F, 8'h2A);
        send(8'h01, 8'h2A);
        check("ign_ready", 32'(ch_ready), 32'd1);
        check_cursor("ign_cursor", 0, 1);

        // LF down to row 29, then LF wraps and clears row 0
        for (int i = 0; i < 28; i++) send(8'h0A, 8'h1E);
        check_cursor("lf_cursor", 0, 29);
        push_clr(0, 80, 8'h1E);
        send(8'h0A, 8'h1E);
        check("lfwrap_busy", 32'(busy), 32'd1);
        check("lfwrap_we", 32'(we), 32'd1);
        repeat (79) begin
            @(posedge clk);
            #1;
        end
        check("lfwrap_busy_last", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("lfwrap_ready", 32'(ch_ready), 32'd1);
        check_cursor("lfwrap_cursor", 0, 0);

        // Printable at col 79 row 29: writes cell 2399, then clears row 0
        for (int i = 0; i < 29; i++) send(8'h0A, 8'h33);
        for (int i = 0; i < 80; i++) begin
            push_cell(2320 + i, 8'h2E, 8'h33);
            send(8'h2E, 8'h33);
        end
        push_clr(0, 80, 8'h33);
        wait_ready(200);
        check("corner_sb_empty", 32'(sb.size()), 32'd0);
        check_cursor("corner_cursor", 0, 0);

        // FF mid-screen; ch_valid while busy must be ignored
        for (int i = 0; i < 5; i++) send(8'h0A, 8'h07);
        push_cell(400, 8'h51, 8'h07);
        send(8'h51, 8'h07);
        push_clr(0, 2400, 8'h07);
        send(8'h0C, 8'h07);
        check_cursor("ff_cursor_early", 0, 0);
        check("ff_busy", 32'(busy), 32'd1);
        ch_data  = 8'h4D;
        ch_valid = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        ch_valid = 1'b0;
        wait_ready(3000);
        check("ff_sb_empty", 32'(sb.size()), 32'd0);
        check_cursor("ff_cursor", 0, 0);

        // Reset during a clear: we drops at once, INIT_CLR restarts
        push_clr(0, 2400, 8'h07);
        send(8'h0C, 8'h07);
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_a", a, Base);
        repeat (2) @(posedge clk);
        push_clr(0, 2400, 8'h0F);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reinit_busy", 32'(busy), 32'd1);
        wait_ready(2500);
        repeat (3) @(posedge clk);
        #1;
        check("reinit_sb_empty", 32'(sb.size()), 32'd0);
        check_cursor("reinit_cursor", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
